// File: rtl/fp_to_fixed_pipe.sv
// IEEE-754 single to fixed-point integer converter, 3-stage valid/ready pipeline.
// Define F2I_ROUND_EN for round-to-nearest-even; default build floors toward -inf.
module fp_to_fixed_pipe #(
    parameter int OUT_W      = 16,
    parameter int FRAC_W     = 5,
    parameter int SIGNED_OUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic [15:0]      sat_count,
    input  logic             clr_count
);

    localparam int STAGES = 3;
    localparam int VW     = 26;
    localparam logic signed [VW-1:0] LIM_HI = $signed({{(VW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [VW-1:0] LIM_LO = $signed({{(VW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});
    localparam logic [OUT_W-1:0] MSB    = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] FLIP   = (SIGNED_OUT != 0) ? '0 : MSB;
    localparam logic [OUT_W-1:0] OUT_HI = ~MSB ^ FLIP;
    localparam logic [OUT_W-1:0] OUT_LO = MSB ^ FLIP;

    logic [STAGES:1]      vld_pipe_q, vld_pipe_d;
    logic                 ld1, ld2, ld3;
    logic                 sign1_q, sign1_d, nan1_q, nan1_d, ovf1_q, ovf1_d;
    logic [23:0]          mant1_q, mant1_d;
    logic [5:0]           rsh1_q, rsh1_d;
    logic                 sign2_q, sign2_d, nan2_q, nan2_d, ovf2_q, ovf2_d;
    logic signed [VW-1:0] val2_q, val2_d;
    logic [OUT_W-1:0]     out_data_q, out_data_d;
    logic                 out_sat_q, out_sat_d;
    logic [15:0]          sat_count_q, sat_count_d;

    logic [7:0]           exp_in;
    logic                 zero_in, special_in, big_in;
    logic signed [10:0]   pexp, rsh_full;
    logic [71:0]          shifted;
    logic [23:0]          int_part;
    logic                 guard, sticky, inc;
    logic [24:0]          mag;
    logic                 sat_hi, sat_lo;

    // A stage loads when the stage below it is empty or draining this cycle.
    always_comb begin
        ld3 = !vld_pipe_q[3] || out_ready;
        ld2 = !vld_pipe_q[2] || ld3;
        ld1 = !vld_pipe_q[1] || ld2;
        vld_pipe_d[1] = ld1 ? in_valid      : vld_pipe_q[1];
        vld_pipe_d[2] = ld2 ? vld_pipe_q[1] : vld_pipe_q[2];
        vld_pipe_d[3] = ld3 ? vld_pipe_q[2] : vld_pipe_q[3];
    end

    // S1: value = mant * 2^(pexp-23); anything at or above 2^OUT_W is flagged overflow.
    always_comb begin
        exp_in     = in_data[30:23];
        zero_in    = (exp_in == 8'h00);
        special_in = (exp_in == 8'hFF);
        pexp       = $signed({3'b000, exp_in}) - 11'sd127 + $signed(11'(FRAC_W));
        big_in     = (pexp >= $signed(11'(OUT_W)));
        rsh_full   = 11'sd23 - pexp;
        sign1_d    = sign1_q;
        nan1_d     = nan1_q;
        ovf1_d     = ovf1_q;
        mant1_d    = mant1_q;
        rsh1_d     = rsh1_q;
        if (ld1 && in_valid) begin
            sign1_d = in_data[31];
            nan1_d  = special_in && (in_data[22:0] != 23'd0);
            ovf1_d  = !zero_in && big_in;
            mant1_d = zero_in ? 24'd0 : {1'b1, in_data[22:0]};
            // Shifts past 49 all give int 0, guard 0, sticky 1.
            if (big_in)                    rsh1_d = 6'd0;
            else if (rsh_full > 11'sd49)   rsh1_d = 6'd49;
            else                           rsh1_d = rsh_full[5:0];
        end
    end

    // S2: align magnitude, round, then apply sign.
    always_comb begin
        shifted  = {mant1_q, 48'd0} >> rsh1_q;
        int_part = shifted[71:48];
        guard    = shifted[47];
        sticky   = |shifted[46:0];
`ifdef F2I_ROUND_EN
        inc      = guard && (sticky || int_part[0]);
`else
        // Floor of a negative value is one more magnitude when any fraction remains.
        inc      = sign1_q && (guard || sticky);
`endif
        mag      = {1'b0, int_part} + {24'd0, inc};
        sign2_d  = sign2_q;
        nan2_d   = nan2_q;
        ovf2_d   = ovf2_q;
        val2_d   = val2_q;
        if (ld2 && vld_pipe_q[1]) begin
            sign2_d = sign1_q;
            nan2_d  = nan1_q;
            ovf2_d  = ovf1_q;
            val2_d  = sign1_q ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        end
    end

    // S3: clamp, offset, and the saturation counter.
    always_comb begin
        sat_hi     = nan2_q || (ovf2_q ? !sign2_q : (val2_q > LIM_HI));
        sat_lo     = !nan2_q && (ovf2_q ? sign2_q : (val2_q < LIM_LO));
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (ld3 && vld_pipe_q[2]) begin
            out_sat_d = sat_hi || sat_lo;
            if (sat_hi)      out_data_d = OUT_HI;
            else if (sat_lo) out_data_d = OUT_LO;
            else             out_data_d = val2_q[OUT_W-1:0] ^ FLIP;
        end
        sat_count_d = sat_count_q;
        if (clr_count)
            sat_count_d = 16'd0;
        else if (vld_pipe_q[3] && out_ready && out_sat_q && (sat_count_q != 16'hFFFF))
            sat_count_d = sat_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            sign1_q     <= 1'b0;
            nan1_q      <= 1'b0;
            ovf1_q      <= 1'b0;
            mant1_q     <= '0;
            rsh1_q      <= '0;
            sign2_q     <= 1'b0;
            nan2_q      <= 1'b0;
            ovf2_q      <= 1'b0;
            val2_q      <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            sign1_q     <= sign1_d;
            nan1_q      <= nan1_d;
            ovf1_q      <= ovf1_d;
            mant1_q     <= mant1_d;
            rsh1_q      <= rsh1_d;
            sign2_q     <= sign2_d;
            nan2_q      <= nan2_d;
            ovf2_q      <= ovf2_d;
            val2_q      <= val2_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign in_ready  = ld1;
    assign out_valid = vld_pipe_q[3];
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fp_to_fixed_pipe.sv
// Directed-vector bench: offset-binary and two's-complement instances driven in lockstep.
module tb_fp_to_fixed_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, clr_count = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready_u, out_valid_u, out_sat_u, in_ready_s, out_valid_s, out_sat_s;
    logic [15:0] out_data_u, sat_count_u, out_data_s, sat_count_s;

    always #5 clk = ~clk;

    fp_to_fixed_pipe dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u), .out_sat(out_sat_u),
        .sat_count(sat_count_u), .clr_count(clr_count));

    fp_to_fixed_pipe #(.SIGNED_OUT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_sat(out_sat_s),
        .sat_count(sat_count_s), .clr_count(clr_count));

`ifdef F2I_ROUND_EN
    localparam logic [15:0] R_U = 16'h8002, R_S = 16'h0002, T_U = 16'h8000, T_S = 16'h0000;
`else
    localparam logic [15:0] R_U = 16'h8001, R_S = 16'h0001, T_U = 16'h7FFF, T_S = 16'hFFFF;
`endif

    localparam int NV = 19;
    logic [31:0] vx [NV] = '{32'h00000000, 32'h3FC00000, 32'hC4800000, 32'h44FA0000, 32'hC59C4000,
                             32'h7FC00000, 32'hBF800000, 32'h3D400000, 32'h3C800000, 32'h80000000,
                             32'hFF800000, 32'h7F800000, 32'h00000001, 32'hBD400000, 32'hBD000000,
                             32'h447FFE00, 32'h44800000, 32'h42C80000, 32'h80800000};
    logic [15:0] vu [NV] = '{16'h8000, 16'h8030, 16'h0000, 16'hFFFF, 16'h0000,
                             16'hFFFF, 16'h7FE0, R_U,      16'h8000, 16'h8000,
                             16'h0000, 16'hFFFF, 16'h8000, 16'h7FFE, 16'h7FFF,
                             16'hFFFF, 16'hFFFF, 16'h8C80, T_U};
    logic [15:0] vs [NV] = '{16'h0000, 16'h0030, 16'h8000, 16'h7FFF, 16'h8000,
                             16'h7FFF, 16'hFFE0, R_S,      16'h0000, 16'h0000,
                             16'h8000, 16'h7FFF, 16'h0000, 16'hFFFE, 16'hFFFF,
                             16'h7FFF, 16'h7FFF, 16'h0C80, T_S};
    bit          vsat [NV] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0};

    typedef struct {
        logic [15:0] u;
        logic [15:0] s;
        logic        sat;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, failures = 0, cyc = 0, exp_cnt = 0, delivered = 0;
    bit          lat_mode = 1'b0, held_vld = 1'b0;
    logic [15:0] held_u, held_s;
    logic        held_sat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One clock: observe outputs 1ns after the falling edge, model the handshakes, advance.
    task automatic step(input int idx, output bit acc);
        exp_t e;
        #1;
        if (out_ready && q.size() == 0) begin
            chk("no_stale_out", out_valid_u, 1'b0);
        end else if (out_valid_u && out_ready) begin
            e = q.pop_front();
            chk("data_u", out_data_u, e.u);
            chk("data_s", out_data_s, e.s);
            chk("sat_u", out_sat_u, e.sat);
            chk("sat_s", out_sat_s, e.sat);
            if (e.lat) chk("latency", cyc - e.cyc, 3);
            delivered++;
            if (!clr_count && e.sat && exp_cnt < 65535) exp_cnt++;
        end
        if (clr_count) exp_cnt = 0;
        if (out_valid_u && !out_ready) begin
            if (held_vld) begin
                chk("stall_hold_u", out_data_u, held_u);
                chk("stall_hold_s", out_data_s, held_s);
                chk("stall_hold_sat", out_sat_u, held_sat);
            end
            held_vld = 1'b1;
            held_u   = out_data_u;
            held_s   = out_data_s;
            held_sat = out_sat_u;
        end else begin
            held_vld = 1'b0;
        end
        acc = in_valid && in_ready_u;
        if (acc) begin
            e.u = vu[idx]; e.s = vs[idx]; e.sat = vsat[idx]; e.cyc = cyc; e.lat = lat_mode;
            q.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input int idx);
        bit a;
        a = 1'b0;
        in_valid = 1'b1;
        in_data  = vx[idx];
        for (int t = 0; t < 10 && !a; t++) step(idx, a);
        in_valid = 1'b0;
        chk("accept", a, 1'b1);
    endtask

    task automatic drain();
        bit a;
        int n;
        n = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && n < 50) begin
            step(0, a);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        bit a;
        int i, d0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid_u, 1'b0);
        chk("rst_out_data", out_data_u, 16'h0000);
        chk("rst_out_sat", out_sat_u, 1'b0);
        chk("rst_sat_count", sat_count_u, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", in_ready_u, 1'b1);
        @(negedge clk);

        // Directed vectors one at a time, consumer always ready.
        lat_mode  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < NV; k++) begin
            send(k);
            drain();
        end
        chk("sat_count_model", sat_count_u, exp_cnt);
        chk("sat_count_hand", sat_count_u, 16'd6);
        chk("sat_count_s", sat_count_s, 16'd6);

        // Back-to-back stream with the consumer stalled for cycles 4..7.
        lat_mode = 1'b0;
        d0 = delivered;
        i  = 0;
        for (int t = 0; t < 40 && i < 8; t++) begin
            in_valid  = 1'b1;
            in_data   = vx[i];
            out_ready = !(t >= 4 && t <= 7);
            step(i, a);
            if (a) i++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("stream_delivered", delivered - d0, 8);
        chk("stream_sat_count", sat_count_u, exp_cnt);

        // Reset with two samples in flight, one already presented at the output.
        send(1);
        in_valid  = 1'b1;
        in_data   = vx[3];
        step(3, a);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step(0, a);
        #1;
        chk("pre_rst_valid", out_valid_u, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid_u, 1'b0);
        chk("mid_rst_data", out_data_u, 16'h0000);
        chk("mid_rst_sat", out_sat_u, 1'b0);
        chk("mid_rst_count", sat_count_u, 16'h0000);
        q.delete();
        exp_cnt  = 0;
        held_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_post_rst", in_ready_u, 1'b1);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (6) step(0, a);

        // clr_count coinciding with a saturated handshake.
        lat_mode = 1'b1;
        send(3);
        drain();
        chk("count_before_clr", sat_count_u, 16'd1);
        send(16);
        step(0, a);
        step(0, a);
        clr_count = 1'b1;
        step(0, a);
        clr_count = 1'b0;
        chk("clr_hs_done", q.size(), 0);
        chk("clr_wins_u", sat_count_u, 16'd0);
        chk("clr_wins_s", sat_count_s, 16'd0);
        send(4);
        drain();
        chk("count_after_clr", sat_count_u, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
